snapshot_axil_reader: RTL and testbench
=======================================

SNAPSHOT_AXIL_READER -- requirements
Module: snapshot_axil_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: AXI-Lite byte-address bits decoded; buffer depth DEPTH = 2^(ADDR_WIDTH-3) words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: sample and AXI data width; fixed at 32.
REQ-003 SHALL have port axi_clock, input, 1: the single clock; every input is sampled and every output is driven on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports din, din_valid and din_last, all inputs, widths 32/1/1: correlator result stream; din_last marks the final beat of a frame.
REQ-006 SHALL have AXI-Lite slave write ports s_axi_awaddr/awprot/awvalid/awready, s_axi_wdata/wstrb/wvalid/wready and s_axi_bresp/bvalid/bready, with widths ADDR_WIDTH/3/1/1, 32/4/1/1 and 2/1/1.
REQ-007 SHALL have AXI-Lite slave read ports s_axi_araddr/arprot/arvalid/arready and s_axi_rdata/rresp/rvalid/rready, with widths ADDR_WIDTH/3/1/1 and 32/2/1/1.
REQ-008 SHALL ignore awprot, arprot and wstrb; every write is treated as a full-word write.

Function
REQ-009 SHALL decode the address space as follows: addr[ADDR_WIDTH-1]=0 selects registers; addr[ADDR_WIDTH-1]=1 selects buffer word addr[ADDR_WIDTH-2:2].
REQ-010 SHALL implement these registers: 0x0 CTRL (bit0 ARM, RW); 0x4 STATUS (bit0 DONE, bit1 BUSY, RO); 0x8 COUNT (words captured, RO); 0xC OVF (see REQ-026).
REQ-011 SHALL implement an FSM with states IDLE, ARMED, CAPTURE and DONE.
REQ-012 SHALL go from IDLE to ARMED on a CTRL write with ARM=1; a write with ARM=0 in any state SHALL return the FSM to IDLE, and COUNT SHALL be retained.
REQ-013 SHALL go from ARMED to CAPTURE on a cycle with din_valid&din_last, so that capture always starts frame-aligned; that beat SHALL NOT be stored, and COUNT SHALL clear.
REQ-014 In CAPTURE, each din_valid SHALL write din to buffer[COUNT] and increment COUNT.
REQ-015 SHALL go from CAPTURE to DONE on the beat carrying din_last (stored) or on the beat that makes COUNT=DEPTH, whichever comes first.
REQ-016 In DONE, SHALL ignore din; a CTRL write with ARM=1 SHALL re-enter ARMED.
REQ-017 SHALL set STATUS.BUSY=1 in ARMED and CAPTURE and STATUS.DONE=1 in DONE.
REQ-018 SHALL accept a write only when awvalid and wvalid are both high and bvalid=0, raising awready and wready together for one cycle; bvalid SHALL assert the next cycle and hold until bready.
REQ-019 SHALL set bresp=OKAY for a write to CTRL and bresp=SLVERR (2'b10) for a write to any other address, with no state change.
REQ-020 SHALL raise arready for one cycle when arvalid=1, no read is pending and rvalid=0; one read outstanding at most.
REQ-021 SHALL use a synchronous buffer read with 1-cycle RAM latency, asserting rvalid exactly 2 cycles after the AR handshake and holding rdata/rvalid stable until rready.
REQ-022 SHALL read unmapped register offsets as 0 with rresp=OKAY, and buffer words beyond COUNT as stale RAM contents.
REQ-023 SHALL serve a buffer read and a capture write in the same cycle without stall (dual-port RAM); a read of the word being written returns old data.

Reset
REQ-024 With rst=1, SHALL enter IDLE and clear COUNT, OVF, ARM, awready, wready, bvalid, arready, rvalid and the pending-read flag; bresp, rresp and rdata SHALL be 0.
REQ-025 Reset mid-transaction SHALL drop the pending response; buffer contents are undefined after reset.

Configuration
REQ-026 With macro SNAPSHOT_OVF_COUNT_EN defined, OVF SHALL be a 32-bit saturating count of din_valid&din_last beats arriving in DONE, cleared on entry to ARMED; without it OVF SHALL read 0 and the counter SHALL not be built.

Verification
REQ-027 SHALL cover: write CTRL=1, send a last beat, then frame 0..9 with last on 9 -> STATUS=0x1, COUNT=10, buffer[0x800..0x824]=0..9.
REQ-028 SHALL cover: arm, then a 600-word frame with ADDR_WIDTH=12 -> DONE after 512 words, COUNT=512, word 511 reads 511.
REQ-029 SHALL cover: read 0x800 with rready held low for 5 cycles -> rvalid rises 2 cycles after arready, rdata is held stable, and no second arready occurs.
REQ-030 SHALL cover: write 0x4 -> bresp=2'b10, STATUS unchanged; read 0x10 -> 0, OKAY.
REQ-031 SHALL cover: with SNAPSHOT_OVF_COUNT_EN defined, 3 frames arriving in DONE -> OVF=3; re-arm -> OVF=0; without the macro, OVF=0 throughout.
REQ-032 SHALL cover: assert rst during CAPTURE and during a pending read -> IDLE, COUNT=0, rvalid=0 the next cycle.

Source files
------------

// File: rtl/snapshot_axil_reader.sv
// Frame-aligned snapshot buffer for a correlator result stream, read back over AXI-Lite.
// Define SNAPSHOT_OVF_COUNT_EN to build the saturating count of frames that arrive while DONE.
module snapshot_axil_reader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  input  logic                    din_last,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 3;
  localparam int unsigned CNT_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 32'(1) << IDX_W;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q;
  logic                    arm_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   ram_q;
  logic                    rd_pend_q;
  logic                    rd_buf_q;
  logic [IDX_W-1:0]        rd_word_q;
  logic [DATA_WIDTH-1:0]   reg_rd_c;
  logic [DATA_WIDTH-1:0]   ovf_rd_c;

  logic wr_hs_c, wr_ctrl_c, ctrl_wr_c, arm_wr_c, rd_hs_c;
  logic busy_c, done_c, cap_we_c, cnt_clr_c;

  assign wr_hs_c   = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign wr_ctrl_c = ~s_axi_awaddr[ADDR_WIDTH-1] && (s_axi_awaddr[ADDR_WIDTH-2:2] == '0);
  assign ctrl_wr_c = wr_hs_c & wr_ctrl_c;
  assign arm_wr_c  = s_axi_wdata[0];
  assign rd_hs_c   = s_axi_arready & s_axi_arvalid;

  // Protection, strobes and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_wdata[DATA_WIDTH-1:1],
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_ff @(posedge axi_clock) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A CTRL write outranks any stream beat arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (ctrl_wr_c) begin
      if (!arm_wr_c)                                    state_d = ST_IDLE;
      else if (state_q == ST_IDLE || state_q == ST_DONE) state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED:   if (din_valid && din_last) state_d = ST_CAPTURE;
        ST_CAPTURE: if (din_valid && (din_last || count_q == CNT_W'(DEPTH - 1))) state_d = ST_DONE;
        default:    ;
      endcase
    end
  end

`ifdef SNAPSHOT_OVF_COUNT_EN
  logic arm_entry_c, ovf_hit_c;
`endif

  always_comb begin
    busy_c    = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    done_c    = (state_q == ST_DONE);
    cap_we_c  = (state_q == ST_CAPTURE) && din_valid && !ctrl_wr_c;
    cnt_clr_c = (state_q == ST_ARMED) && din_valid && din_last && !ctrl_wr_c;
`ifdef SNAPSHOT_OVF_COUNT_EN
    arm_entry_c = (state_d == ST_ARMED) && (state_q != ST_ARMED);
    ovf_hit_c   = (state_q == ST_DONE) && din_valid && din_last && !ctrl_wr_c;
`endif
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      count_q <= '0;
      arm_q   <= 1'b0;
    end else begin
      if (ctrl_wr_c) arm_q <= arm_wr_c;
      if (cnt_clr_c)     count_q <= '0;
      else if (cap_we_c) count_q <= count_q + CNT_W'(1);
    end
  end

  // Dual-port buffer: capture write and AXI read never contend; same-word read sees old data.
  always_ff @(posedge axi_clock) begin
    if (cap_we_c) mem[count_q[IDX_W-1:0]] <= din;
    if (rd_hs_c)  ram_q <= mem[s_axi_araddr[ADDR_WIDTH-2:2]];
  end

`ifdef SNAPSHOT_OVF_COUNT_EN
  logic [31:0] ovf_q;
  always_ff @(posedge axi_clock) begin
    if (rst)                               ovf_q <= '0;
    else if (arm_entry_c)                  ovf_q <= '0;
    else if (ovf_hit_c && ovf_q != '1)     ovf_q <= ovf_q + 32'd1;
  end
  assign ovf_rd_c = DATA_WIDTH'(ovf_q);
`else
  assign ovf_rd_c = '0;
`endif

  always_comb begin
    reg_rd_c = '0;
    case (rd_word_q)
      IDX_W'(0): reg_rd_c = DATA_WIDTH'(arm_q);
      IDX_W'(1): reg_rd_c = {{(DATA_WIDTH-2){1'b0}}, busy_c, done_c};
      IDX_W'(2): reg_rd_c = DATA_WIDTH'(count_q);
      IDX_W'(3): reg_rd_c = ovf_rd_c;
      default:   reg_rd_c = '0;
    endcase
  end

  // Write channel: single-cycle ready pulse, response held until bready.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      if (wr_hs_c) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ctrl_c ? 2'b00 : 2'b10;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: AR handshake -> RAM access -> response, one read in flight.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
      rd_pend_q     <= 1'b0;
      rd_buf_q      <= 1'b0;
      rd_word_q     <= '0;
    end else begin
      s_axi_arready <= s_axi_arvalid && !rd_pend_q && !s_axi_rvalid && !s_axi_arready;
      if (rd_hs_c) begin
        rd_pend_q <= 1'b1;
        rd_buf_q  <= s_axi_araddr[ADDR_WIDTH-1];
        rd_word_q <= s_axi_araddr[ADDR_WIDTH-2:2];
      end
      if (rd_pend_q) begin
        rd_pend_q    <= 1'b0;
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_buf_q ? ram_q : reg_rd_c;
        s_axi_rresp  <= 2'b00;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snapshot_axil_reader.sv
// Directed-plus-random bench for snapshot_axil_reader against a frame-level capture model.
module tb_snapshot_axil_reader;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 512;
`ifdef SNAPSHOT_OVF_COUNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   din;
  logic          din_valid, din_last;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  snapshot_axil_reader dut (
    .axi_clock(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_last(din_last),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int checks   = 0;
  int failures = 0;

  // Model: 0 = idle, 1 = waiting for a frame boundary, 2 = filling, 3 = full/finished
  int          m_stage;
  int          m_count;
  logic        m_arm;
  logic [31:0] m_ovf;
  logic [31:0] m_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    if (m_stage == 1 || m_stage == 2) return 32'h2;
    if (m_stage == 3) return 32'h1;
    return 32'h0;
  endfunction

  function automatic logic [AW-1:0] buf_addr(input int idx);
    return AW'(32'h800 + 32'(idx) * 32'd4);
  endfunction

  task automatic model_reset();
    m_stage = 0; m_count = 0; m_arm = 1'b0; m_ovf = '0;
  endtask

  task automatic model_beat(input logic [31:0] d, input bit last);
    case (m_stage)
      1: if (last) begin m_stage = 2; m_count = 0; end
      2: begin
        m_mem[m_count] = d;
        m_count++;
        if (last || m_count == DEPTH) m_stage = 3;
      end
      3: if (last && OVF_EN && m_ovf != 32'hffff_ffff) m_ovf++;
      default: ;
    endcase
  endtask

  task automatic beat(input logic [31:0] d, input bit last);
    din = d; din_valid = 1'b1; din_last = last;
    tick();
    model_beat(d, last);
    din_valid = 1'b0; din_last = 1'b0; din = $urandom;
    if ($urandom_range(0, 3) == 0) tick();
  endtask

  task automatic send_frame(input int n, input bit idx_data);
    for (int i = 0; i < n; i++) beat(idx_data ? 32'(i) : $urandom, i == n - 1);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
    bit hs;
    logic [1:0] resp;
    hs = 1'b0; resp = 2'b11;
    awaddr = a; wdata = d; wstrb = 4'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (awready) begin
        hs = 1'b1;
        check("wready_with_awready", 32'(wready), 32'd1);
      end
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_handshake", 32'(hs), 32'd1);
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (bvalid) begin hs = 1'b1; resp = bresp; end
      tick();
    end
    check("b_response", 32'(hs), 32'd1);
    if (a[AW-1] == 1'b0 && a[AW-2:2] == '0) begin
      check("bresp_ctrl", 32'(resp), 32'd0);
      if (d[0]) begin
        m_arm = 1'b1;
        if (m_stage == 0 || m_stage == 3) begin m_stage = 1; m_ovf = '0; end
      end else begin
        m_arm = 1'b0; m_stage = 0;
      end
    end else begin
      check("bresp_slverr", 32'(resp), 32'd2);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit hs, got;
    int lat;
    hs = 1'b0; got = 1'b0; data = 'x; resp = 'x;
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (arready) hs = 1'b1;
      tick();
    end
    arvalid = 1'b0;
    check("ar_handshake", 32'(hs), 32'd1);
    lat = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid) begin
        got = 1'b1; data = rdata; resp = rresp;
      end else lat++;
      tick();
    end
    check("r_response", 32'(got), 32'd1);
    if (got) check("r_latency", 32'(lat), 32'd2);
  endtask

  task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(tag, d, exp);
    check({tag, "_rresp"}, 32'(r), 32'd0);
  endtask

  task automatic check_regs();
    check_reg("ctrl", AW'(0), 32'(m_arm));
    check_reg("status", AW'(4), exp_status());
    check_reg("count", AW'(8), 32'(m_count));
    check_reg("ovf", AW'(12), m_ovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit          hs;
    int          lat, idx, n;

    rst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();
    check_regs();

    // Aligned capture of a 10-word frame
    axi_write(AW'(0), 32'h1);
    check_reg("status_armed", AW'(4), 32'h2);
    beat($urandom, 1'b1);
    send_frame(10, 1'b1);
    check_regs();
    check_reg("status_done_10", AW'(4), 32'h1);
    for (int i = 0; i < 10; i++) check_reg("buf_idx", buf_addr(i), 32'(i));

    // Illegal writes and unmapped reads
    axi_write(AW'(4), $urandom);
    check_reg("status_after_bad_wr", AW'(4), exp_status());
    axi_write(AW'(12'h800), 32'hdead_beef);
    check_reg("buf0_after_bad_wr", buf_addr(0), m_mem[0]);
    check_reg("unmapped_0x10", AW'(12'h10), 32'h0);
    check_reg("unmapped_0x7fc", AW'(12'h7fc), 32'h0);

    // Frames arriving while finished
    for (int f = 0; f < 3; f++) begin
      beat($urandom, 1'b0);
      send_frame($urandom_range(1, 5), 1'b0);
    end
    check_reg("ovf_after_3", AW'(12), OVF_EN ? 32'd3 : 32'd0);
    check_regs();
    axi_write(AW'(0), 32'h1);
    check_reg("ovf_after_rearm", AW'(12), 32'd0);
    check_regs();

    // Overlong frame stops at the buffer depth
    beat($urandom, 1'b1);
    send_frame(600, 1'b1);
    check_regs();
    check_reg("count_full", AW'(8), 32'd512);
    check_reg("word511", buf_addr(511), 32'd511);
    for (int i = 0; i < 3; i++) begin
      idx = $urandom_range(0, DEPTH - 1);
      check_reg("buf_full_rand", buf_addr(idx), m_mem[idx]);
    end

    // Disarm mid-capture keeps the partial count
    axi_write(AW'(0), 32'h1);
    beat($urandom, 1'b1);
    for (int i = 0; i < 5; i++) beat($urandom, 1'b0);
    axi_write(AW'(0), 32'h0);
    beat($urandom, 1'b1);
    check_regs();
    check_reg("count_retained", AW'(8), 32'd5);

    // Randomized frames, with non-boundary beats ahead of the alignment beat
    for (int k = 0; k < 4; k++) begin
      axi_write(AW'(0), 32'h1);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) beat($urandom, 1'b0);
      beat($urandom, 1'b1);
      send_frame($urandom_range(1, 40), 1'b0);
      check_regs();
      for (int i = 0; i < 3; i++) begin
        idx = $urandom_range(0, m_count - 1);
        check_reg("buf_rand", buf_addr(idx), m_mem[idx]);
      end
    end

    // Read held off by rready: data stable, no second AR accepted
    araddr = AW'(12'h800); arvalid = 1'b1; rready = 1'b0; hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (arready) hs = 1'b1;
      tick();
    end
    check("hold_ar_handshake", 32'(hs), 32'd1);
    lat = 1;
    for (int i = 0; i < 20 && !rvalid; i++) begin
      check("hold_no_2nd_arready", 32'(arready), 32'd0);
      tick();
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("hold_rvalid", 32'(rvalid), 32'd1);
      check("hold_rdata", rdata, m_mem[0]);
      check("hold_no_2nd_arready", 32'(arready), 32'd0);
      tick();
    end
    arvalid = 1'b0; rready = 1'b1;
    tick();
    check("hold_released", 32'(rvalid), 32'd0);

    // Reset during capture with a read in flight
    axi_write(AW'(0), 32'h1);
    beat($urandom, 1'b1);
    for (int i = 0; i < 3; i++) beat($urandom, 1'b0);
    araddr = AW'(8); arvalid = 1'b1; rready = 1'b0; hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (arready) hs = 1'b1;
      tick();
    end
    arvalid = 1'b0;
    check("rst_ar_handshake", 32'(hs), 32'd1);
    rst = 1'b1;
    tick();
    model_reset();
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_arready", 32'(arready), 32'd0);
    rst = 1'b0; rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_dropped_read", 32'(rvalid), 32'd0);
    end
    check_regs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
